tensor_core_arbiter: RTL and testbench
======================================

TENSOR_CORE_ARBITER -- requirements
Module: tensor_core_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters (warps) sharing one tensor_core.
REQ-002 Parameter LATENCY, default 3: tensor_core valid_in-to-valid_out latency in cycles.
REQ-003 Parameter TAG_DEPTH, default 4: in-flight tag FIFO depth; SHALL be at least LATENCY+1 and a power of two.
REQ-004 Port clk, input, 1: clock; all state SHALL be on the rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous, active-high.
REQ-006 Port en, input, 1: when 1, new grants are allowed.
REQ-007 Port req_valid, input, NUM_REQ: per-requester request for an MMA operation.
REQ-008 Port req_opcode, input, NUM_REQ x 8: per-requester opcode.
REQ-009 Port req_ready, output, NUM_REQ: one-hot grant; a handshake occurs where req_valid and req_ready are both 1.
REQ-010 Port tc_valid_in, output, 1: drives tensor_core valid_in.
REQ-011 Port tc_opcode, output, 8: opcode of the granted requester; 0 when there is no grant.
REQ-012 Port tc_sel, output, clog2(NUM_REQ): granted requester index, used by the external operand mux; 0 when there is no grant.
REQ-013 Port tc_valid_out, input, 1: tensor_core valid_out.
REQ-014 Port rsp_valid, output, NUM_REQ: one-hot, asserted for one cycle when a requester's matrix_d is valid.
REQ-015 Port rsp_id, output, clog2(NUM_REQ): index of the responding requester.
REQ-016 Port busy, output, NUM_REQ: requester has an operation in flight.
REQ-017 Port idle, output, 1: no operation in flight and no grant this cycle.
REQ-018 Port err, output, 1: sticky protocol error flag.

Function
REQ-019 A requester is eligible when req_valid[i]=1, busy[i]=0, en=1, and the tag FIFO is not full.
REQ-020 Grant SHALL be round-robin: search starts at register rr_ptr and increments modulo NUM_REQ; the first eligible index wins.
REQ-021 Grant is combinational in the same cycle: req_ready, tc_valid_in=|req_ready, tc_sel and tc_opcode are all valid together.
REQ-022 At most one grant per cycle; back-to-back grants to different requesters every cycle SHALL be sustained.
REQ-023 On a grant to index g: rr_ptr becomes (g+1) mod NUM_REQ, busy[g] is set, and g is pushed to the tag FIFO at the clock edge.
REQ-024 When tc_valid_out=1 and the FIFO is non-empty, in the same cycle: rsp_valid[head]=1, rsp_id=head; at the edge the FIFO pops and busy[head] clears.
REQ-025 busy is a register; a requester whose busy clears at edge T is first eligible in cycle T+1.
REQ-026 Push and pop in the same cycle are allowed when the FIFO is not full; occupancy is then unchanged.
REQ-027 When the FIFO is full, no grant is issued, even if a pop occurs in the same cycle.
REQ-028 If tc_valid_out=1 while the FIFO is empty: err is set (sticky), rsp_valid stays 0, and no state changes.
REQ-029 en=0 blocks only new grants; operations already in flight complete and respond normally.
REQ-030 idle = (FIFO empty) and (no grant this cycle).
REQ-031 Pointers are clog2(TAG_DEPTH) bits and wrap modulo TAG_DEPTH; occupancy counter is clog2(TAG_DEPTH)+1 bits.

Reset
REQ-032 On rst=1, immediately and asynchronously: rr_ptr=0, busy=0, FIFO empty, err=0.
REQ-033 While rst=1: req_ready=0, tc_valid_in=0, tc_sel=0, tc_opcode=0, rsp_valid=0, rsp_id=0, idle=1.
REQ-034 Reset mid-operation SHALL discard all in-flight tags; the integrator ties the same rst to tensor_core so that it also drops its pipeline.

Structure
REQ-035 A shared package SHALL hold: the tc_opcode_t 8-bit typedef, the default NUM_REQ/LATENCY/TAG_DEPTH constants, and the req_id_t typedef.
REQ-036 The tag FIFO SHALL be one sub-module, tag_fifo, with parameters WIDTH and DEPTH; arbitration and busy tracking stay in the top.

Verification
REQ-037 Single request: req_valid=0001 at cycle 0 -> req_ready=0001, tc_valid_in=1, tc_sel=0 in cycle 0; with a model core, rsp_valid=0001, rsp_id=0 in cycle 3; busy[0] is 1 for cycles 1-3.
REQ-038 All four requesting continuously from reset -> grants 0,1,2,3 in cycles 0-3; responses in cycles 3-6 in the same order; requester 0 is re-granted in cycle 4.
REQ-039 FIFO full: TAG_DEPTH=4 with a core model of latency 6 and all requesting -> 4 grants, then no grants until the first pop; then exactly one grant per pop; err stays 0.
REQ-040 Spurious tc_valid_out=1 with the FIFO empty -> err=1 and held, rsp_valid=0; a later legal operation still completes correctly.
REQ-041 en dropped to 0 after 2 grants -> no further req_ready; both responses arrive; then idle=1.
REQ-042 rst pulsed 1 cycle after 3 grants -> busy=0, idle=1, rr_ptr=0, no rsp_valid afterwards; the next request to index 2 is granted the cycle it arrives.

Source files
------------

// File: rtl/tensor_core_arbiter_pkg.sv
// Shared types and default sizing for the tensor-core arbiter slice.
package tensor_core_arbiter_pkg;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_LATENCY   = 3;
  localparam int DEF_TAG_DEPTH = 4;

  typedef logic [7:0]                      tc_opcode_t;
  typedef logic [$clog2(DEF_NUM_REQ)-1:0]  req_id_t;

endpackage

// File: rtl/tag_fifo.sv
// In-flight tag FIFO: remembers which requester owns each result still inside the core.
module tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: storage has no reset; occupancy guarantees no entry is read before it is written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tensor_core_arbiter.sv
// Round-robin arbiter sharing one pipelined tensor core among NUM_REQ warps.
module tensor_core_arbiter
  import tensor_core_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int LATENCY   = DEF_LATENCY,
  parameter int TAG_DEPTH = DEF_TAG_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  tc_opcode_t [NUM_REQ-1:0]   req_opcode,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tc_valid_in,
  output tc_opcode_t                 tc_opcode,
  output logic [$clog2(NUM_REQ)-1:0] tc_sel,
  input  logic                       tc_valid_out,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [NUM_REQ-1:0]         busy,
  output logic                       idle,
  output logic                       err
);

  localparam int ID_W = $clog2(NUM_REQ);

  if (TAG_DEPTH < LATENCY + 1 || (TAG_DEPTH & (TAG_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("tensor_core_arbiter: TAG_DEPTH must be a power of two and at least LATENCY+1");
  end

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    cand;
  logic [ID_W-1:0]    head_id;
  logic               grant_found;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant_oh;
  logic [NUM_REQ-1:0] rsp_oh;
  logic               fifo_empty;
  logic               fifo_full;
  logic               rsp_fire;

  // A full FIFO blocks grants even when a pop is happening this cycle.
  assign eligible = (en && !fifo_full && !rst) ? (req_valid & ~busy) : '0;

  always_comb begin
    // NOTE: defaults come first so every path assigns every output and no latch is inferred.
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign grant_oh    = grant_found ? (NUM_REQ'(1) << grant_idx) : '0;
  assign req_ready   = grant_oh;
  assign tc_valid_in = grant_found;
  assign tc_sel      = grant_idx;
  assign tc_opcode   = grant_found ? req_opcode[grant_idx] : '0;

  assign rsp_fire  = tc_valid_out && !fifo_empty;
  assign rsp_oh    = rsp_fire ? (NUM_REQ'(1) << head_id) : '0;
  assign rsp_valid = rsp_oh;
  assign rsp_id    = rsp_fire ? head_id : '0;
  assign idle      = fifo_empty && !grant_found;

  tag_fifo #(
    .WIDTH (ID_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (grant_found),
    .push_data (grant_idx),
    .pop       (rsp_fire),
    .head      (head_id),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      busy   <= '0;
      err    <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (grant_found)
        rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
      // A requester never holds a grant and a response in the same cycle: grant needs busy=0.
      busy <= (busy | grant_oh) & ~rsp_oh;
      if (tc_valid_out && fifo_empty) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tensor_core_arbiter.sv
// Directed and randomized bench for tensor_core_arbiter against a queue-based reference model.
module tb_tensor_core_arbiter;

  localparam int N     = 4;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0][7:0] req_opcode = '0;
  logic [N-1:0]     req_ready;
  logic             tc_valid_in;
  logic [7:0]       tc_opcode;
  logic [1:0]       tc_sel;
  logic             tc_valid_out;
  logic [N-1:0]     rsp_valid;
  logic [1:0]       rsp_id;
  logic [N-1:0]     busy;
  logic             idle;
  logic             err;

  // Core model: fixed-latency valid pipeline plus an injectable spurious pulse.
  logic [15:0] pipe;
  int          core_lat = 3;
  logic        spur = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model state.
  logic [N-1:0] m_busy;
  int           m_rr;
  int           m_q[$];
  logic         m_err;

  // Observation logs for directed scenario checks.
  int grant_log[$];
  int rsp_cnt;
  int last_rsp_cyc;

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) pipe <= '0;
    else     pipe <= {pipe[14:0], tc_valid_in};
  end

  assign tc_valid_out = pipe[core_lat-1] | spur;

  tensor_core_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .req_valid    (req_valid),
    .req_opcode   (req_opcode),
    .req_ready    (req_ready),
    .tc_valid_in  (tc_valid_in),
    .tc_opcode    (tc_opcode),
    .tc_sel       (tc_sel),
    .tc_valid_out (tc_valid_out),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .busy         (busy),
    .idle         (idle),
    .err          (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int log_at(int i);
    return (i < grant_log.size()) ? grant_log[i] : -1;
  endfunction

  // One clock cycle: inputs are already set; compare at the falling edge, then advance.
  task automatic step();
    int   g;
    int   head;
    bit   rsp;
    @(negedge clk);
    if (rst) begin
      m_busy = '0;
      m_rr   = 0;
      m_q.delete();
      m_err  = 1'b0;
    end
    g = -1;
    if (!rst && en && m_q.size() < DEPTH) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_rr + k) % N;
        if (g < 0 && req_valid[i] && !m_busy[i]) g = i;
      end
    end
    rsp  = tc_valid_out && (m_q.size() > 0);
    head = rsp ? m_q[0] : 0;

    check("req_ready",   req_ready,   (g >= 0) ? (1 << g) : 0);
    check("tc_valid_in", tc_valid_in, (g >= 0) ? 1 : 0);
    check("tc_sel",      tc_sel,      (g >= 0) ? g : 0);
    check("tc_opcode",   tc_opcode,   (g >= 0) ? req_opcode[g] : 0);
    check("rsp_valid",   rsp_valid,   rsp ? (1 << head) : 0);
    check("rsp_id",      rsp_id,      head);
    check("busy",        busy,        m_busy);
    check("idle",        idle,        (m_q.size() == 0 && g < 0) ? 1 : 0);
    check("err",         err,         m_err);

    if (tc_valid_in) grant_log.push_back(int'(tc_sel));
    if (|rsp_valid) begin
      rsp_cnt++;
      last_rsp_cyc = cyc;
    end

    if (!rst) begin
      if (tc_valid_out && m_q.size() == 0) m_err = 1'b1;
      if (rsp) begin
        m_busy[head] = 1'b0;
        void'(m_q.pop_front());
      end
      if (g >= 0) begin
        m_busy[g] = 1'b1;
        m_rr      = (g + 1) % N;
        m_q.push_back(g);
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    req_valid = '0;
    spur      = 1'b0;
    rst       = 1'b1;
    step();
    rst       = 1'b0;
    cyc       = 0;
    grant_log.delete();
    rsp_cnt   = 0;
  endtask

  initial begin
    int base;
    m_busy = '0; m_rr = 0; m_err = 1'b0; rsp_cnt = 0; last_rsp_cyc = -1;
    req_opcode = {8'h44, 8'h33, 8'h22, 8'h11};

    // Reset state held for two cycles.
    #1;
    steps(2);
    rst = 1'b0;
    cyc = 0;

    // Single request: grant in cycle 0, response in cycle 3.
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0000;
    steps(6);
    check("single_grant_id", log_at(0), 0);
    check("single_rsp_cycle", last_rsp_cyc, 3);
    check("single_rsp_count", rsp_cnt, 1);

    // All four requesting from reset: grants 0,1,2,3 then 0 again in cycle 4.
    do_reset();
    req_valid = 4'b1111;
    steps(8);
    req_valid = '0;
    steps(8);
    check("rr_seq0", log_at(0), 0);
    check("rr_seq1", log_at(1), 1);
    check("rr_seq2", log_at(2), 2);
    check("rr_seq3", log_at(3), 3);
    check("rr_seq4", log_at(4), 0);

    // FIFO full with a 6-cycle core: 4 grants, none until the first pop, then one per pop.
    do_reset();
    core_lat  = 6;
    req_valid = 4'b1111;
    steps(7);
    check("full_grants_c0_6", grant_log.size(), 4);
    steps(13);
    req_valid = '0;
    steps(10);
    check("full_no_err", err, 0);
    check("full_drained_idle", idle, 1);
    core_lat = 3;

    // Spurious valid_out with nothing in flight sets a sticky error.
    do_reset();
    spur = 1'b1;
    step();
    spur = 1'b0;
    steps(2);
    rsp_cnt   = 0;
    req_valid = 4'b0010;
    req_opcode[1] = 8'hA5;
    step();
    req_valid = '0;
    steps(5);
    check("spur_err_sticky", err, 1);
    check("spur_later_rsp", rsp_cnt, 1);

    // en dropped after two grants: in-flight work still completes.
    do_reset();
    req_valid = 4'b1111;
    steps(2);
    en = 1'b0;
    steps(8);
    check("en_grants", grant_log.size(), 2);
    check("en_rsps", rsp_cnt, 2);
    check("en_idle", idle, 1);
    en = 1'b1;
    req_valid = '0;

    // Reset one cycle after three grants drops everything in flight.
    do_reset();
    req_valid = 4'b1111;
    steps(3);
    req_valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    grant_log.delete();
    rsp_cnt = 0;
    steps(6);
    check("rst_no_rsp", rsp_cnt, 0);
    check("rst_busy", busy, 0);
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    check("rst_regrant_idx", log_at(0), 2);
    steps(5);

    // Randomized traffic in a few phases with differing core latency.
    for (int ph = 0; ph < 4; ph++) begin
      do_reset();
      core_lat = $urandom_range(1, 6);
      for (int c = 0; c < 150; c++) begin
        req_valid = N'($urandom);
        en        = ($urandom_range(0, 9) != 0);
        for (int r = 0; r < N; r++) req_opcode[r] = 8'($urandom);
        step();
      end
      req_valid = '0;
      en        = 1'b1;
      steps(10);
      check("rand_drain_idle", idle, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
